agc_prefix_sequencer: RTL and testbench

- Parametrised instruction-prefix sequencer between the AGC fetch stage and the main decoder.
- Buffers fetched words in a small FIFO and consumes EXTEND and INDEX prefix words itself, including the memory read that INDEX needs for its operand.
- Emits one resolved instruction per handshake: the effective (indexed) word plus extracode and indexed flags.
- The downstream decoder therefore never sees prefix words and holds no prefix state of its own.

---
 rtl/agc_prefix_sequencer_if.sv | 36 +++
 rtl/agc_prefix_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_agc_prefix_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/agc_prefix_sequencer_if.sv
// Bus bundle for agc_prefix_sequencer: fetch input, INDEX operand read port and
// resolved-instruction output.
// Handshake: a word moves on in_*/out_* at a rising clock edge where valid & ready
// are both high; the sender keeps valid and data stable until that edge.
// idx_req is a one-cycle request pulse; idx_valid is a one-cycle return strobe.
interface agc_prefix_sequencer_if #(
   parameter int WORD_W = 15,
   parameter int ADDR_W = 12
);
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_instr;
   logic [ADDR_W-1:0] in_pc;
   logic              idx_req;
   logic [ADDR_W-1:0] idx_addr;
   logic              idx_valid;
   logic [WORD_W-1:0] idx_data;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              out_extracode;
   logic              out_indexed;

   modport slave (
      input  in_valid, in_instr, in_pc, idx_valid, idx_data, out_ready,
      output in_ready, idx_req, idx_addr, out_valid, out_instr, out_pc,
             out_extracode, out_indexed
   );

   modport master (
      output in_valid, in_instr, in_pc, idx_valid, idx_data, out_ready,
      input  in_ready, idx_req, idx_addr, out_valid, out_instr, out_pc,
             out_extracode, out_indexed
   );
endinterface

// File: rtl/agc_prefix_sequencer.sv
// AGC prefix sequencer: FIFO of fetched words, absorbs EXTEND/INDEX prefixes and emits
// resolved instructions. Macro AGC_ONES_COMP_INDEX_EN selects ones'-complement index add.
module agc_prefix_sequencer #(
   parameter int WORD_W = 15,
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic                   flush,
   agc_prefix_sequencer_if.slave  bus,
   output logic                   busy,
   output logic [1:0]             dbg_state
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [WORD_W-1:0] EXTEND_WORD = WORD_W'(6);

   typedef enum logic [1:0] {RUN, WAIT_IDX, IDX_PEND, DRAIN_IDX} state_t;
   state_t state, state_nxt;

   logic [WORD_W-1:0] fifo_instr [DEPTH];
   logic [ADDR_W-1:0] fifo_pc    [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     count;

   logic              ext_pend, ext_nxt;
   logic [WORD_W-1:0] idx_reg, idx_reg_nxt;
   logic              idx_req_q, idx_req_nxt;
   logic [ADDR_W-1:0] idx_addr_q, idx_addr_nxt;

   logic              out_valid_q, out_ext_q, out_idx_q;
   logic [WORD_W-1:0] out_instr_q;
   logic [ADDR_W-1:0] out_pc_q;

   logic              in_ready, push, pop, load, head_vld, out_free, is_index;
   logic [WORD_W-1:0] head_instr, idx_sum, ld_instr;
   logic [ADDR_W-1:0] head_pc;
   logic              ld_ext, ld_idx;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign in_ready   = (count < CW'(DEPTH));
   assign push       = bus.in_valid & in_ready & ~flush;
   assign head_vld   = (count != '0);
   assign head_instr = fifo_instr[rd_ptr];
   assign head_pc    = fifo_pc[rd_ptr];
   assign out_free   = ~out_valid_q | bus.out_ready;
   assign is_index   = (head_instr[WORD_W-1 -: 5] == 5'b10100) |
                       (ext_pend & (head_instr[WORD_W-1 -: 3] == 3'b101));

`ifdef AGC_ONES_COMP_INDEX_EN
   logic [WORD_W:0] idx_wide;
   assign idx_wide = {1'b0, head_instr} + {1'b0, idx_reg};
   assign idx_sum  = idx_wide[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, idx_wide[WORD_W]};
`else
   assign idx_sum  = head_instr + idx_reg;
`endif

   always_comb begin
      state_nxt    = state;
      ext_nxt      = ext_pend;
      idx_reg_nxt  = idx_reg;
      idx_req_nxt  = 1'b0;
      idx_addr_nxt = idx_addr_q;
      pop          = 1'b0;
      load         = 1'b0;
      ld_instr     = head_instr;
      ld_ext       = ext_pend;
      ld_idx       = 1'b0;
      if (flush) begin
         ext_nxt = 1'b0;
         // An operand read still in flight must be swallowed; if it returns in this
         // very cycle there is nothing left to drain.
         if ((state == WAIT_IDX || state == DRAIN_IDX) && !bus.idx_valid)
            state_nxt = DRAIN_IDX;
         else
            state_nxt = RUN;
      end else begin
         unique case (state)
            RUN: begin
               if (head_vld) begin
                  if (head_instr == EXTEND_WORD) begin
                     pop     = 1'b1;
                     ext_nxt = 1'b1;
                  end else if (is_index) begin
                     pop          = 1'b1;
                     idx_req_nxt  = 1'b1;
                     idx_addr_nxt = head_instr[ADDR_W-1:0];
                     state_nxt    = WAIT_IDX;
                  end else if (out_free) begin
                     pop     = 1'b1;
                     load    = 1'b1;
                     ext_nxt = 1'b0;
                  end
               end
            end
            WAIT_IDX: begin
               if (bus.idx_valid) begin
                  idx_reg_nxt = bus.idx_data;
                  state_nxt   = IDX_PEND;
               end
            end
            IDX_PEND: begin
               // The word after INDEX is the indexed operand, never a prefix.
               if (head_vld && out_free) begin
                  pop       = 1'b1;
                  load      = 1'b1;
                  ld_instr  = idx_sum;
                  ld_idx    = 1'b1;
                  ext_nxt   = 1'b0;
                  state_nxt = RUN;
               end
            end
            DRAIN_IDX: begin
               if (bus.idx_valid) state_nxt = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_instr[wr_ptr] <= bus.in_instr;
         fifo_pc[wr_ptr]    <= bus.in_pc;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         ext_pend   <= 1'b0;
         idx_reg    <= '0;
         idx_req_q  <= 1'b0;
         idx_addr_q <= '0;
      end else begin
         state      <= state_nxt;
         ext_pend   <= ext_nxt;
         idx_reg    <= idx_reg_nxt;
         idx_req_q  <= idx_req_nxt;
         idx_addr_q <= idx_addr_nxt;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         out_ext_q   <= 1'b0;
         out_idx_q   <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_instr_q <= ld_instr;
         out_pc_q    <= head_pc;
         out_ext_q   <= ld_ext;
         out_idx_q   <= ld_idx;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.idx_req       = idx_req_q;
   assign bus.idx_addr      = idx_addr_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_instr     = out_instr_q;
   assign bus.out_pc        = out_pc_q;
   assign bus.out_extracode = out_ext_q;
   assign bus.out_indexed   = out_idx_q;
   assign busy              = head_vld | out_valid_q | (state != RUN);
   assign dbg_state         = state;
endmodule

// File: tb/tb_agc_prefix_sequencer.sv
// Bench for agc_prefix_sequencer: directed scenarios with literal expectations plus a
// randomized word stream checked against a stream-level prefix model.
module tb_agc_prefix_sequencer;
  localparam int WORD_W = 15;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam int VW     = WORD_W + ADDR_W + 2;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  logic busy;
  logic [1:0] dbg_state;

  agc_prefix_sequencer_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) sif ();

  agc_prefix_sequencer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .rst       (rst),
    .flush     (flush),
    .bus       (sif.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic [VW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [WORD_W-1:0] idx_mem [4096];
  bit chk_en = 1'b0;
  bit rand_ready = 1'b0;
  int resp_delay = 1;
  int hs_count = 0;

  // stream model state: prefixes seen so far in the pushed word stream
  bit m_ext = 1'b0;
  bit m_idx_pend = 1'b0;
  logic [ADDR_W-1:0] m_idx_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/none expected event", name);
  endtask

  function automatic logic [WORD_W-1:0] model_add(input int a, input int b);
    int s;
    s = a + b;
`ifdef AGC_ONES_COMP_INDEX_EN
    if (s >= (1 << WORD_W)) s = s - (1 << WORD_W) + 1;
`else
    s = s % (1 << WORD_W);
`endif
    return WORD_W'(s);
  endfunction

  task automatic model_push(input logic [WORD_W-1:0] w, input logic [ADDR_W-1:0] pc);
    if (m_idx_pend) begin
      exp_q.push_back({model_add(int'(w), int'(idx_mem[m_idx_addr])), pc, m_ext, 1'b1});
      m_idx_pend = 1'b0;
      m_ext = 1'b0;
    end else if (w == 15'o00006) begin
      m_ext = 1'b1;
    end else if (w[14:10] == 5'b10100 || (m_ext && w[14:12] == 3'b101)) begin
      m_idx_pend = 1'b1;
      m_idx_addr = w[ADDR_W-1:0];
      exp_addr_q.push_back(w[ADDR_W-1:0]);
    end else begin
      exp_q.push_back({w, pc, m_ext, 1'b0});
      m_ext = 1'b0;
    end
  endtask

  // driver tasks: called at posedge+#1
  task automatic push(input logic [WORD_W-1:0] w, input logic [ADDR_W-1:0] pc);
    bit ok;
    ok = 1'b0;
    sif.in_valid = 1'b1;
    sif.in_instr = w;
    sif.in_pc    = pc;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = sif.in_ready;
      @(posedge clock);
      #1;
    end
    sif.in_valid = 1'b0;
    if (ok) model_push(w, pc);
    else report_fail("push_timeout");
  endtask

  task automatic expect_out(input string name, input logic [WORD_W-1:0] instr,
                            input logic [ADDR_W-1:0] pc, input logic ext, input logic idx);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (sif.out_valid) begin
        seen = 1'b1;
        check(name, {sif.out_instr, sif.out_pc, sif.out_extracode, sif.out_indexed},
              {instr, pc, ext, idx});
      end else begin
        @(posedge clock);
        #1;
      end
    end
    if (!seen) report_fail(name);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      if (!busy && exp_q.size() == 0 && exp_addr_q.size() == 0) idle = 1'b1;
      else begin
        @(posedge clock);
        #1;
      end
    end
    if (!idle) report_fail("idle_timeout");
  endtask

  function automatic logic [WORD_W-1:0] rand_word();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1:    return 15'o00006;
      2, 3:    return {5'b10100, 10'($urandom_range(0, 1023))};
      4:       return {3'b101, 12'($urandom_range(0, 4095))};
      default: return 15'($urandom_range(0, 32767));
    endcase
  endfunction

  // scoreboard: output handshakes against the model, stall stability
  initial begin
    logic [VW-1:0] held;
    logic [VW-1:0] cur;
    bit stall;
    stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clock);
      if (chk_en) begin
        cur = {sif.out_instr, sif.out_pc, sif.out_extracode, sif.out_indexed};
        if (stall) begin
          check("hold_valid", {31'b0, sif.out_valid}, 32'd1);
          check("hold_data", cur, held);
        end
        if (sif.out_valid && sif.out_ready) begin
          hs_count++;
          if (exp_q.size() == 0) report_fail("unexpected_out");
          else check("out", cur, exp_q.pop_front());
        end
        stall = sif.out_valid && !sif.out_ready;
        held = cur;
      end else begin
        stall = 1'b0;
      end
    end
  end

  // memory responder for INDEX operand reads
  initial begin
    bit pend;
    int cnt;
    logic [WORD_W-1:0] rdata;
    pend = 1'b0;
    cnt = 0;
    rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      sif.idx_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          sif.idx_valid = 1'b1;
          sif.idx_data  = rdata;
          pend = 1'b0;
        end else cnt--;
      end
      if (chk_en && sif.idx_req) begin
        if (pend) report_fail("idx_req_overlap");
        if (exp_addr_q.size() == 0) report_fail("unexpected_idx_req");
        else check("idx_addr", {20'b0, sif.idx_addr}, {20'b0, exp_addr_q.pop_front()});
        rdata = idx_mem[sif.idx_addr];
        pend  = 1'b1;
        cnt   = (resp_delay < 0) ? int'($urandom_range(0, 3)) : resp_delay;
      end
    end
  end

  // random backpressure
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) sif.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int hs0;
    logic [ADDR_W-1:0] pc;
    sif.in_valid  = 1'b0;
    sif.in_instr  = '0;
    sif.in_pc     = '0;
    sif.idx_valid = 1'b0;
    sif.idx_data  = '0;
    sif.out_ready = 1'b0;
    for (int i = 0; i < 4096; i++) idx_mem[i] = 15'($urandom_range(0, 32767));

    rst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'b0, sif.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, sif.out_valid}, 32'd0);
    check("rst_idx_req", {31'b0, sif.idx_req}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_data", {sif.out_instr, sif.out_pc, sif.out_extracode, sif.out_indexed}, 32'd0);
    check("rst_idx_addr", {20'b0, sif.idx_addr}, 32'd0);

    chk_en = 1'b1;
    sif.out_ready = 1'b1;
    resp_delay = 1;

    push(15'o00006, 12'o0100);
    push(15'o30100, 12'o0101);
    expect_out("extend_word", 15'o30100, 12'o0101, 1'b1, 1'b0);
    wait_idle();

    idx_mem[12'o0020] = 15'o00003;
    push(15'o50020, 12'o0200);
    push(15'o30005, 12'o0201);
    expect_out("index_word", 15'o30010, 12'o0201, 1'b0, 1'b1);
    wait_idle();

    idx_mem[12'o0020] = 15'o00002;
    push(15'o00006, 12'o0300);
    push(15'o50020, 12'o0301);
    push(15'o70001, 12'o0302);
    expect_out("ext_index_word", 15'o70003, 12'o0302, 1'b1, 1'b1);
    wait_idle();

    idx_mem[12'o0040] = 15'o77777;
    push(15'o50040, 12'o0400);
    push(15'o00001, 12'o0401);
`ifdef AGC_ONES_COMP_INDEX_EN
    expect_out("index_overflow", 15'o00001, 12'o0401, 1'b0, 1'b1);
`else
    expect_out("index_overflow", 15'o00000, 12'o0401, 1'b0, 1'b1);
`endif
    wait_idle();

    sif.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(15'(15'o10000 + i), 12'(12'o0500 + i));
    check("in_ready_full", {31'b0, sif.in_ready}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("held_first_valid", {31'b0, sif.out_valid}, 32'd1);
    check("held_first_instr", {17'b0, sif.out_instr}, {17'b0, 15'o10000});
    sif.out_ready = 1'b1;
    hs0 = hs_count;
    repeat (DEPTH + 1) @(posedge clock);
    #1;
    check("burst_len", 32'(hs_count - hs0), 32'(DEPTH + 1));
    check("burst_done", {31'b0, sif.out_valid}, 32'd0);
    wait_idle();

    resp_delay = 6;
    idx_mem[12'o0020] = 15'o00005;
    push(15'o50020, 12'o0600);
    repeat (2) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    exp_q.delete();
    m_ext = 1'b0;
    m_idx_pend = 1'b0;
    check("busy_drain", {31'b0, busy}, 32'd1);
    push(15'o30100, 12'o0601);
    expect_out("flush_word", 15'o30100, 12'o0601, 1'b0, 1'b0);
    wait_idle();

    resp_delay = -1;
    rand_ready = 1'b1;
    pc = 12'o1000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end else begin
        push(rand_word(), pc);
        pc = pc + 12'd1;
      end
    end
    push(15'o00000, pc);
    rand_ready = 1'b0;
    sif.out_ready = 1'b1;
    wait_idle();
    repeat (4) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
